// File: rtl/uart_line_monitor_pkg.sv
// Shared types and constants for the UART line monitor.
package uart_line_monitor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam logic [7:0] AsciiLf  = 8'h0A;
  localparam logic [7:0] AsciiEoc = 8'h14;

  // 16x oversample divisor, floored, never below 1.
  function automatic int unsigned calc_divisor(int unsigned clk_hz, int unsigned baud);
    int unsigned div;
    div = clk_hz / (baud * 16);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_line_monitor_rx.sv
// Serial front end: input synchronizer, 16x tick generator and bit-level receive FSM.
module uart_line_monitor_rx
  import uart_line_monitor_pkg::*;
#(
  parameter int unsigned Divisor  = 10,
  parameter int unsigned DataBits = 8,
  parameter int unsigned ParityEn = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int unsigned DivW = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam bit HasParity = (ParityEn != 0);

  logic meta_q, sync_q, prev_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  rx_state_e state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic tick, fall;

  assign tick = (div_cnt_q == DivW'(Divisor - 1));
  assign fall = prev_q & ~sync_q;
  assign byte_data_o = 8'(shreg_q);

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    byte_valid_o = 1'b0;
    parity_err_o = 1'b0;
    frame_err_o  = 1'b0;
    div_cnt_d    = tick ? '0 : div_cnt_q + DivW'(1);
    if (tick && state_q != StIdle && state_q != StWaitHigh) tcnt_d = tcnt_q + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          // Realign the oversample phase to the start edge.
          state_d   = StStart;
          tcnt_d    = '0;
          div_cnt_d = '0;
        end
      end
      StStart: begin
        if (tick && tcnt_q == 4'd7) begin
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (tick && tcnt_q == 4'd15) begin
          tcnt_d  = '0;
          shreg_d = {sync_q, shreg_q[DataBits-1:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'(DataBits - 1)) state_d = HasParity ? StParity : StStop;
        end
      end
      StParity: begin
        if (tick && tcnt_q == 4'd15) begin
          tcnt_d       = '0;
          parity_err_o = (sync_q != ^shreg_q);
          state_d      = StStop;
        end
      end
      StStop: begin
        if (tick && tcnt_q == 4'd15) begin
          tcnt_d = '0;
          if (sync_q) begin
            byte_valid_o = 1'b1;
            state_d      = StIdle;
          end else begin
            frame_err_o = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      prev_q    <= 1'b1;
      div_cnt_q <= '0;
      state_q   <= StIdle;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
    end else begin
      meta_q    <= rx_i;
      sync_q    <= meta_q;
      prev_q    <= sync_q;
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
    end
  end

endmodule

// File: rtl/uart_line_monitor.sv
// UART line monitor top: line buffer, ack handshake and sticky error flags.
// Optional end-of-capture marker enabled by defining UART_LINE_MONITOR_EOC_EN.
module uart_line_monitor
  import uart_line_monitor_pkg::*;
#(
  parameter int unsigned ClkFreqHz  = 20_000_000,
  parameter int unsigned BaudRate   = 115200,
  parameter int unsigned DataBits   = 8,
  parameter int unsigned ParityEn   = 0,
  parameter int unsigned MaxLineLen = 80,
  localparam int unsigned LenW  = $clog2(MaxLineLen + 1),
  localparam int unsigned AddrW = $clog2(MaxLineLen)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            uart_rx_i,
  output logic            line_valid_o,
  output logic [LenW-1:0] line_len_o,
  output logic            line_trunc_o,
  input  logic            line_ack_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [7:0]      rd_data_o,
  output logic            parity_err_o,
  output logic            frame_err_o,
  output logic            overrun_o,
  input  logic            err_clr_i,
  output logic            eoc_o
);

  localparam int unsigned Divisor = calc_divisor(ClkFreqHz, BaudRate);

  logic       byte_valid, parity_err, frame_err;
  logic [7:0] byte_data;

  uart_line_monitor_rx #(
    .Divisor  (Divisor),
    .DataBits (DataBits),
    .ParityEn (ParityEn)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (uart_rx_i),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err)
  );

  logic [7:0] mem [MaxLineLen];
  logic [LenW-1:0] cnt_q, cnt_d, base_cnt;
  logic valid_q, valid_d, trunc_q, trunc_d, base_valid, ack_eff, wr_en, ovr_set;
  logic perr_q, ferr_q, ovr_q;
  logic [7:0] rd_data_q;
`ifdef UART_LINE_MONITOR_EOC_EN
  logic eoc_q, eoc_set;
`endif

  always_comb begin
    // An ack in the same cycle as a byte frees the buffer before the byte lands.
    ack_eff    = line_ack_i & valid_q;
    base_cnt   = ack_eff ? '0 : cnt_q;
    base_valid = valid_q & ~ack_eff;
    valid_d    = base_valid;
    trunc_d    = trunc_q & ~ack_eff;
    cnt_d      = base_cnt;
    wr_en      = 1'b0;
    ovr_set    = 1'b0;
`ifdef UART_LINE_MONITOR_EOC_EN
    eoc_set    = 1'b0;
`endif
    if (byte_valid) begin
      if (base_valid) begin
        ovr_set = 1'b1;
      end else if (byte_data == AsciiLf) begin
        if (base_cnt != '0) valid_d = 1'b1;
`ifdef UART_LINE_MONITOR_EOC_EN
      end else if (byte_data == AsciiEoc) begin
        eoc_set = 1'b1;
`endif
      end else begin
        wr_en = 1'b1;
        cnt_d = base_cnt + LenW'(1);
        if (cnt_d == LenW'(MaxLineLen)) begin
          valid_d = 1'b1;
          trunc_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[base_cnt[AddrW-1:0]] <= byte_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      trunc_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      trunc_q   <= trunc_d;
      perr_q    <= (perr_q & ~err_clr_i) | parity_err;
      ferr_q    <= (ferr_q & ~err_clr_i) | frame_err;
      ovr_q     <= (ovr_q & ~err_clr_i) | ovr_set;
      rd_data_q <= mem[rd_addr_i];
    end
  end

`ifdef UART_LINE_MONITOR_EOC_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) eoc_q <= 1'b0;
    else if (eoc_set) eoc_q <= 1'b1;
  end
  assign eoc_o = eoc_q;
`else
  assign eoc_o = 1'b0;
`endif

  assign line_valid_o = valid_q;
  assign line_len_o   = valid_q ? cnt_q : '0;
  assign line_trunc_o = trunc_q;
  assign rd_data_o    = rd_data_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;

endmodule
